// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_DATA  = 2'd1;
  localparam logic [1:0] ARB_INST  = 2'd2;
  localparam logic [1:0] ARB_DRAIN = 2'd3;

  localparam int ARB_TIMEOUT_W = 8;
  localparam int REG_BUS_W     = 32;
  localparam int INST_ADDR_W   = 32;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Serialises fetch and data accesses onto one variable-latency bus, data first,
// buffering results and stalling the pipeline until the cycle's accesses finish.
//
// state | meaning
// IDLE  | no bus access; picks data, then fetch
// DATA  | data access on the bus, waiting for ack
// INST  | fetch access on the bus, waiting for ack
// DRAIN | flushed access still on the bus; result is discarded
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   inst_ce_i,
  input  logic [INST_ADDR_W-1:0] inst_addr_i,
  output logic [REG_BUS_W-1:0]   inst_data_o,
  input  logic                   data_ce_i,
  input  logic                   data_we_i,
  input  logic [3:0]             data_sel_i,
  input  logic [REG_BUS_W-1:0]   data_addr_i,
  input  logic [REG_BUS_W-1:0]   data_wdata_i,
  output logic [REG_BUS_W-1:0]   data_rdata_o,
  output logic                   stallreq_o,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [3:0]             bus_sel_o,
  output logic [REG_BUS_W-1:0]   bus_addr_o,
  output logic [REG_BUS_W-1:0]   bus_wdata_o,
  input  logic [REG_BUS_W-1:0]   bus_rdata_i,
  input  logic                   bus_ack_i,
  output logic                   bus_timeout_o
);

  localparam logic [ARB_TIMEOUT_W-1:0] TO_LAST = ARB_TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ARB_TIMEOUT_W-1:0] CNT_ONE = ARB_TIMEOUT_W'(1);

  logic [1:0]               state_q, state_d;
  logic                     bus_req_q, bus_req_d;
  logic                     bus_we_q, bus_we_d;
  logic [3:0]               bus_sel_q, bus_sel_d;
  logic [REG_BUS_W-1:0]     bus_addr_q, bus_addr_d;
  logic [REG_BUS_W-1:0]     bus_wdata_q, bus_wdata_d;
  logic                     inst_done_q, inst_done_d;
  logic                     data_done_q, data_done_d;
  logic [ARB_TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [REG_BUS_W-1:0]     inst_buf_q, inst_buf_d;
  logic [REG_BUS_W-1:0]     data_buf_q, data_buf_d;
  logic                     timeout_q, timeout_d;

  logic data_pend, inst_pend, stall_int, ack_hit, to_hit;

  assign data_pend = data_ce_i & ~data_done_q;
  assign inst_pend = inst_ce_i & ~inst_done_q;
  assign stall_int = data_pend | inst_pend | (state_q == ARB_DRAIN);
  assign ack_hit   = bus_req_q & bus_ack_i;
  // Timeout fires on the edge where the counter would reach TIMEOUT_CYCLES.
  assign to_hit    = bus_req_q & ~bus_ack_i & (cnt_q == TO_LAST);

  // Gated with reset so the stall releases immediately, without a clock edge.
  assign stallreq_o    = rst & stall_int;
  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = bus_we_q;
  assign bus_sel_o     = bus_sel_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign inst_data_o   = inst_buf_q;
  assign data_rdata_o  = data_buf_q;
  assign bus_timeout_o = timeout_q;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    inst_done_d = inst_done_q;
    data_done_d = data_done_q;
    inst_buf_d  = inst_buf_q;
    data_buf_d  = data_buf_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;

    if (ack_hit || to_hit) begin
      cnt_d = '0;
    end else if (bus_req_q) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (!stall_int) begin
      inst_done_d = 1'b0;
      data_done_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (!flush) begin
          if (data_pend) begin
            state_d     = ARB_DATA;
            bus_req_d   = 1'b1;
            bus_we_d    = data_we_i;
            bus_sel_d   = data_sel_i;
            bus_addr_d  = data_addr_i;
            bus_wdata_d = data_wdata_i;
          end else if (inst_pend) begin
            state_d     = ARB_INST;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_sel_d   = 4'b1111;
            bus_addr_d  = inst_addr_i;
            bus_wdata_d = '0;
          end
        end
      end
      ARB_DATA, ARB_INST: begin
        if (flush) begin
          if (ack_hit || to_hit) begin
            state_d   = ARB_IDLE;
            bus_req_d = 1'b0;
            if (to_hit) timeout_d = 1'b1;
          end else begin
            state_d = ARB_DRAIN;
          end
        end else if (ack_hit || to_hit) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
          if (to_hit) timeout_d = 1'b1;
          if (state_q == ARB_DATA) begin
            data_done_d = 1'b1;
            if (ack_hit && !bus_we_q) data_buf_d = bus_rdata_i;
          end else begin
            inst_done_d = 1'b1;
            inst_buf_d  = ack_hit ? bus_rdata_i : '0;
          end
        end
      end
      default: begin
        if (ack_hit || to_hit) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
          if (to_hit) timeout_d = 1'b1;
        end
      end
    endcase

    if (flush) begin
      inst_done_d = 1'b0;
      data_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
      cnt_q       <= '0;
      inst_buf_q  <= '0;
      data_buf_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      inst_done_q <= inst_done_d;
      data_done_q <= data_done_d;
      cnt_q       <= cnt_d;
      inst_buf_q  <= inst_buf_d;
      data_buf_q  <= data_buf_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, data priority, store, flush/drain,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(255)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .inst_ce_i     (inst_ce_i),
    .inst_addr_i   (inst_addr_i),
    .inst_data_o   (inst_data_o),
    .data_ce_i     (data_ce_i),
    .data_we_i     (data_we_i),
    .data_sel_i    (data_sel_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .stallreq_o    (stallreq_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_sel_o     (bus_sel_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_rdata_i   (bus_rdata_i),
    .bus_ack_i     (bus_ack_i),
    .bus_timeout_o (bus_timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int req_cnt;
    rst = 1'b0; flush = 1'b0;
    inst_ce_i = 1'b0; inst_addr_i = '0;
    data_ce_i = 1'b0; data_we_i = 1'b0; data_sel_i = '0; data_addr_i = '0; data_wdata_i = '0;
    bus_rdata_i = '0; bus_ack_i = 1'b0;
    #2;
    chk("rst_req", bus_req_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_inst", inst_data_o, 0);
    chk("rst_data", data_rdata_o, 0);
    chk("rst_to", bus_timeout_o, 0);
    cyc(); cyc(); rst = 1'b1;

    // 1: fetch only, ack in the third request cycle
    cyc(); inst_ce_i = 1'b1; inst_addr_i = 32'h100;
    smp(); chk("t1_c0_stall", stallreq_o, 1); chk("t1_c0_req", bus_req_o, 0);
    cyc(); smp(); chk("t1_c1_req", bus_req_o, 1); chk("t1_c1_addr", bus_addr_o, 32'h100);
    chk("t1_c1_sel", bus_sel_o, 4'hf); chk("t1_c1_we", bus_we_o, 0);
    cyc(); smp(); chk("t1_c2_req", bus_req_o, 1);
    cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h3401_0020;
    smp(); chk("t1_c3_req", bus_req_o, 1); chk("t1_c3_stall", stallreq_o, 1);
    cyc(); bus_ack_i = 1'b0;
    smp(); chk("t1_c4_req", bus_req_o, 0); chk("t1_c4_inst", inst_data_o, 32'h3401_0020);
    chk("t1_c4_stall", stallreq_o, 0);
    cyc(); smp(); chk("t1_c5_doneclr", stallreq_o, 1); chk("t1_c5_req", bus_req_o, 0);
    cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h3401_0024;
    smp(); chk("t1_c6_req", bus_req_o, 1);
    cyc(); bus_ack_i = 1'b0;
    smp(); chk("t1_c7_inst", inst_data_o, 32'h3401_0024); chk("t1_c7_stall", stallreq_o, 0);
    cyc(); inst_ce_i = 1'b0;

    // 2: simultaneous fetch and load, data wins
    cyc(); inst_ce_i = 1'b1; inst_addr_i = 32'h104;
    data_ce_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hf; data_addr_i = 32'h2000;
    smp(); chk("t2_c0_stall", stallreq_o, 1); chk("t2_c0_req", bus_req_o, 0);
    cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA_0001;
    smp(); chk("t2_c1_req", bus_req_o, 1); chk("t2_c1_addr", bus_addr_o, 32'h2000);
    chk("t2_c1_we", bus_we_o, 0);
    cyc(); bus_ack_i = 1'b0;
    smp(); chk("t2_c2_gap", bus_req_o, 0); chk("t2_c2_stall", stallreq_o, 1);
    chk("t2_c2_data", data_rdata_o, 32'hAAAA_0001);
    cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'hBBBB_0002;
    smp(); chk("t2_c3_req", bus_req_o, 1); chk("t2_c3_addr", bus_addr_o, 32'h104);
    chk("t2_c3_sel", bus_sel_o, 4'hf); chk("t2_c3_stall", stallreq_o, 1);
    cyc(); bus_ack_i = 1'b0;
    smp(); chk("t2_c4_stall", stallreq_o, 0); chk("t2_c4_inst", inst_data_o, 32'hBBBB_0002);
    chk("t2_c4_data", data_rdata_o, 32'hAAAA_0001);
    cyc(); inst_ce_i = 1'b0; data_ce_i = 1'b0;

    // 3: store
    cyc(); data_ce_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'b0011;
    data_addr_i = 32'h3000; data_wdata_i = 32'hDEAD_BEEF;
    cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h7777_7777;
    smp(); chk("t3_req", bus_req_o, 1); chk("t3_we", bus_we_o, 1);
    chk("t3_sel", bus_sel_o, 4'b0011); chk("t3_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    chk("t3_addr", bus_addr_o, 32'h3000);
    cyc(); bus_ack_i = 1'b0;
    smp(); chk("t3_req_drop", bus_req_o, 0); chk("t3_stall", stallreq_o, 0);
    chk("t3_data_keep", data_rdata_o, 32'hAAAA_0001);
    cyc(); data_ce_i = 1'b0; data_we_i = 1'b0;

    // 4: flush during a fetch, drained ack discarded, then new fetch
    cyc(); inst_ce_i = 1'b1; inst_addr_i = 32'h140;
    cyc(); flush = 1'b1;
    smp(); chk("t4_req", bus_req_o, 1); chk("t4_addr", bus_addr_o, 32'h140);
    cyc(); flush = 1'b0; inst_addr_i = 32'h180;
    smp(); chk("t4_drain_req", bus_req_o, 1); chk("t4_drain_stall", stallreq_o, 1);
    cyc(); cyc();
    smp(); chk("t4_drain_hold", bus_req_o, 1);
    cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    cyc(); bus_ack_i = 1'b0;
    smp(); chk("t4_post_req", bus_req_o, 0); chk("t4_keep", inst_data_o, 32'hBBBB_0002);
    chk("t4_post_stall", stallreq_o, 1);
    cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h2222_0003;
    smp(); chk("t4_new_req", bus_req_o, 1); chk("t4_new_addr", bus_addr_o, 32'h180);
    cyc(); bus_ack_i = 1'b0;
    smp(); chk("t4_new_inst", inst_data_o, 32'h2222_0003); chk("t4_new_stall", stallreq_o, 0);
    cyc(); inst_ce_i = 1'b0;

    // 5: no ack, timeout after 255 request cycles
    cyc(); inst_ce_i = 1'b1; inst_addr_i = 32'h200;
    smp(); chk("t5_to_before", bus_timeout_o, 0);
    req_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      cyc(); smp();
      if (bus_req_o) req_cnt++;
    end
    chk("t5_req_cycles", req_cnt, 255);
    cyc(); smp();
    chk("t5_req_drop", bus_req_o, 0); chk("t5_to", bus_timeout_o, 1);
    chk("t5_inst_zero", inst_data_o, 0); chk("t5_stall", stallreq_o, 0);
    cyc(); inst_ce_i = 1'b0;
    cyc(); smp(); chk("t5_to_sticky", bus_timeout_o, 1);

    // 6: asynchronous reset in the middle of a data access
    cyc(); data_ce_i = 1'b1; data_addr_i = 32'h4000; data_sel_i = 4'hf;
    cyc(); smp(); chk("t6_req", bus_req_o, 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_req", bus_req_o, 0); chk("t6_async_stall", stallreq_o, 0);
    chk("t6_async_to", bus_timeout_o, 0);
    cyc(); rst = 1'b1;
    smp(); chk("t6_rs_stall", stallreq_o, 1); chk("t6_rs_req", bus_req_o, 0);
    chk("t6_rs_data", data_rdata_o, 0);
    cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_0005;
    smp(); chk("t6_rs_busreq", bus_req_o, 1); chk("t6_rs_addr", bus_addr_o, 32'h4000);
    cyc(); bus_ack_i = 1'b0;
    smp(); chk("t6_rs_rdata", data_rdata_o, 32'h5555_0005); chk("t6_rs_done", stallreq_o, 0);
    cyc(); data_ce_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port, variable-latency memory bus between the instruction-fetch port (pc_reg/if_id side) and the data port (mem stage) of the openmips core.
- Serialises the two requests, giving data priority over fetch.
- Holds returned data in buffers and raises a stall request to ctrl until every pending access in the current pipeline cycle has completed.
- Supports flush, including draining a bus access that is already in flight.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles to wait for bus_ack_i before abandoning an access (8-bit counter, range 1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
flush  in  1  pipeline flush from ctrl
inst_ce_i  in  1  fetch request valid
inst_addr_i  in  32  fetch address
inst_data_o  out  32  fetched instruction (buffered)
data_ce_i  in  1  data request valid
data_we_i  in  1  1 = write
data_sel_i  in  4  byte enables
data_addr_i  in  32  data address
data_wdata_i  in  32  write data
data_rdata_o  out  32  load data (buffered)
stallreq_o  out  1  stall request to ctrl
bus_req_o  out  1  bus request, held until ack
bus_we_o  out  1  bus write enable
bus_sel_o  out  4  bus byte enables
bus_addr_o  out  32  bus address
bus_wdata_o  out  32  bus write data
bus_rdata_i  in  32  bus read data, valid with ack
bus_ack_i  in  1  one-cycle completion strobe
bus_timeout_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0; state IDLE; inst_done=0, data_done=0; timeout counter 0; both buffers 0.
- Pending definitions:
  - data_pend = data_ce_i & ~data_done
  - inst_pend = inst_ce_i & ~inst_done
  - stallreq_o = data_pend | inst_pend, combinational.
  - stallreq_o is also forced to 1 in DRAIN.
- Requests are combinational from the core and stay stable while stallreq_o=1.
- States: IDLE, DATA, INST, DRAIN.
- IDLE:
  - If data_pend, go to DATA; otherwise if inst_pend, go to INST.
  - On the transition, the bus_* outputs are registered from the winning port.
  - bus_req_o rises one cycle after the request is seen.
  - For INST: bus_we_o=0 and bus_sel_o=4'b1111.
- DATA / INST:
  - bus_req_o and the bus fields are held constant until bus_ack_i.
  - On ack:
    - bus_req_o drops on the next edge.
    - For a data read, bus_rdata_i is latched into data_rdata_o; for INST, into inst_data_o. Data writes leave data_rdata_o unchanged.
    - The matching done flag is set and the state returns to IDLE.
  - Back-to-back accesses: after a data ack, a pending fetch starts from IDLE on the next cycle. The minimum bus-idle gap between accesses is 1 cycle.
- Latency: request seen at cycle 0, bus_req_o at cycle 1, ack at the earliest in cycle 1, data visible and stallreq_o=0 at cycle 2.
- Done-flag clear: on any edge where stallreq_o=0 (pipeline advances), both done flags are cleared.
- Flush (priority over everything except reset):
  - Both done flags are cleared.
  - In DATA or INST: go to DRAIN, holding bus_req_o until ack, then discard the data (no buffer update) and return to IDLE.
  - In IDLE: state is unchanged.
  - Flush coincident with ack: the returned data is discarded; go to IDLE.
- Timeout:
  - The counter increments each cycle bus_req_o=1 without ack.
  - When it reaches TIMEOUT_CYCLES, the access is abandoned:
    - bus_req_o drops;
    - the done flag is set, and the buffer is loaded with 32'h0 (fetch) or left unchanged (data);
    - bus_timeout_o is set to 1 and stays set until reset;
    - state returns to IDLE.
  - The counter clears on ack, on timeout, and on leaving DRAIN. It does not wrap.
- Simultaneous data_pend and inst_pend in IDLE: data is served first, then fetch.
- Reset mid-access: bus_req_o drops immediately; the bus slave is required to tolerate an abandoned request.

Decomposition:
- Shared package / defines.v additions:
  - `ArbIdle, `ArbData, `ArbInst, `ArbDrain (2-bit state codes)
  - `ArbTimeoutW = 8
- Reuse the existing `RegBus and `InstAddrBus widths.
- No sub-module; a single FSM plus registers.

Test Plan:
1. Fetch only, inst_addr_i=32'h100, ack 3 cycles after req with rdata=32'h3401_0020.
   - bus_req_o high for cycles 1..3; inst_data_o=32'h3401_0020 in cycle 4; stallreq_o low from cycle 4; inst_done cleared next edge.
2. Simultaneous fetch 32'h104 and load 32'h2000 (sel 4'b1111), ack latency 1 each.
   - Data address on the bus first; fetch request starts after a 1-cycle gap.
   - stallreq_o stays 1 until both complete; data_rdata_o and inst_data_o both valid the cycle stallreq_o drops.
3. Store (we=1, sel=4'b0011, wdata=32'hDEAD_BEEF).
   - bus_we_o=1, bus_sel_o=4'b0011, bus_wdata_o=32'hDEAD_BEEF; data_rdata_o unchanged after ack.
4. Flush during INST with ack 4 cycles later, rdata=32'h1111_1111.
   - DRAIN entered; inst_data_o keeps its old value; then the new fetch at 32'h180 is issued.
5. No ack, TIMEOUT_CYCLES=255.
   - bus_req_o drops after 255 cycles; bus_timeout_o=1 and stays set; inst_data_o=0; stallreq_o releases.
6. Assert rst=0 asynchronously mid-DATA.
   - bus_req_o and stallreq_o go to 0 without a clock edge; the FSM restarts cleanly after rst=1.
